// File: rtl/mem_wb_ctrl.sv
// Writeback-stage sequencer for the 16-bit WISC core: decodes the destination and
// writeback source, runs LD/ST/STU through a multi-cycle memory handshake, fires one write.
module mem_wb_ctrl #(
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  input  logic        mem_done,
  input  logic        mem_err,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic        stall,
  output logic        wb_en,
  output logic [1:0]  wb_sel,
  output logic [2:0]  wb_reg,
  output logic [15:0] ld_data,
  output logic        err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             mem_req_q, mem_req_d;
  logic             mem_wr_q, mem_wr_d;
  logic             stall_q, stall_d;
  logic             wb_en_q, wb_en_d;
  logic [1:0]       wb_sel_q, wb_sel_d;
  logic [2:0]       wb_reg_q, wb_reg_d;
  logic [15:0]      ld_data_q, ld_data_d;
  logic             err_q, err_d;
  logic             mwr_q, mwr_d;
  logic             is_ld_q, is_ld_d;

  logic [4:0]       op;
  logic             dec_wr, dec_mem, dec_st;
  logic [1:0]       dec_sel;
  logic [2:0]       dec_reg;
  logic             mem_fin;

  assign op = instr[15:11];

  always_comb begin
    dec_wr  = 1'b0;
    dec_sel = 2'd0;
    dec_reg = 3'd0;
    dec_mem = 1'b0;
    dec_st  = 1'b0;
    casez (op)
      5'b11011, 5'b111??: begin
        dec_wr  = 1'b1;
        dec_reg = instr[4:2];
      end
      5'b010??, 5'b101??, 5'b11001: begin
        dec_wr  = 1'b1;
        dec_reg = instr[7:5];
      end
      5'b10001: begin
        dec_wr  = 1'b1;
        dec_reg = instr[7:5];
        dec_sel = 2'd1;
        dec_mem = 1'b1;
      end
      5'b11000, 5'b10010: begin
        dec_wr  = 1'b1;
        dec_reg = instr[10:8];
      end
      5'b10011: begin
        dec_wr  = 1'b1;
        dec_reg = instr[10:8];
        dec_mem = 1'b1;
        dec_st  = 1'b1;
      end
      5'b10000: begin
        dec_mem = 1'b1;
        dec_st  = 1'b1;
      end
      5'b0011?: begin
        dec_wr  = 1'b1;
        dec_reg = 3'd7;
        dec_sel = 2'd2;
      end
      default: ;
    endcase
  end

  // Saturating count of cycles spent in REQ/WAIT.
  assign cnt_inc = (cnt_q == TO_CNT) ? cnt_q : cnt_q + 1'b1;
  // In REQ, completion also needs the request to be accepted in the same cycle.
  assign mem_fin = (state_q == S_WAIT) ? mem_done : (mem_ready & mem_done);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_req_d = mem_req_q;
    mem_wr_d  = mem_wr_q;
    stall_d   = stall_q;
    wb_en_d   = 1'b0;
    wb_sel_d  = wb_sel_q;
    wb_reg_d  = wb_reg_q;
    ld_data_d = ld_data_q;
    err_d     = err_q;
    mwr_d     = mwr_q;
    is_ld_d   = is_ld_q;
    case (state_q)
      S_IDLE: begin
        if (issue && dec_mem) begin
          state_d   = S_REQ;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          mem_wr_d  = dec_st;
          stall_d   = 1'b1;
          wb_sel_d  = dec_sel;
          wb_reg_d  = dec_reg;
          mwr_d     = dec_wr;
          is_ld_d   = ~dec_st;
        end else if (issue && dec_wr) begin
          wb_en_d  = 1'b1;
          wb_sel_d = dec_sel;
          wb_reg_d = dec_reg;
        end
      end
      S_REQ, S_WAIT: begin
        cnt_d = cnt_inc;
        if (mem_err) begin
          state_d   = S_ERR;
          err_d     = 1'b1;
          stall_d   = 1'b1;
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
        end else if (mem_fin) begin
          state_d   = S_DONE;
          stall_d   = 1'b0;
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
          wb_en_d   = mwr_q;
          if (is_ld_q) ld_data_d = mem_rdata;
        end else if (cnt_inc == TO_CNT) begin
          state_d   = S_ERR;
          err_d     = 1'b1;
          stall_d   = 1'b1;
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
        end else if (state_q == S_REQ && mem_ready) begin
          state_d   = S_WAIT;
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      mem_wr_q  <= 1'b0;
      stall_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_sel_q  <= 2'd0;
      wb_reg_q  <= 3'd0;
      ld_data_q <= 16'd0;
      err_q     <= 1'b0;
      mwr_q     <= 1'b0;
      is_ld_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_req_q <= mem_req_d;
      mem_wr_q  <= mem_wr_d;
      stall_q   <= stall_d;
      wb_en_q   <= wb_en_d;
      wb_sel_q  <= wb_sel_d;
      wb_reg_q  <= wb_reg_d;
      ld_data_q <= ld_data_d;
      err_q     <= err_d;
      mwr_q     <= mwr_d;
      is_ld_q   <= is_ld_d;
    end
  end

  // Stall must rise in the issue cycle itself, before the FSM has registered anything.
  assign stall   = stall_q | ((state_q == S_IDLE) & issue & dec_mem);
  assign mem_req = mem_req_q;
  assign mem_wr  = mem_wr_q;
  assign wb_en   = wb_en_q;
  assign wb_sel  = wb_sel_q;
  assign wb_reg  = wb_reg_q;
  assign ld_data = ld_data_q;
  assign err     = err_q;

endmodule
